eth_fcs_checker: RTL

//  Receive-side Ethernet FCS checker: consumes a byte stream framed by sof/eof,

---
 rtl/crc_32_byte_package.sv | 33 +++
 rtl/fcs_delay_line.sv | 39 +++
 rtl/eth_fcs_checker.sv | 118 +++++++++++
 3 files changed

// File: rtl/crc_32_byte_package.sv
// CRC-32 arithmetic shared by the Ethernet TX FCS generator and the RX FCS
// checker. Bytes are bit-reversed into the MSB end of an MSB-first register.
// The final value is bit-reversed and inverted. This gives the standard
// Ethernet FCS. The result is packed {b3,b2,b1,b0}, where b0 goes on the wire first.
package crc_32_byte_package;

  localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
  localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF;

  typedef enum logic {IDLE, RX} fcs_chk_state_t;

  function automatic logic [7:0] crc_reverse_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Bit-reverse and invert: turns the raw register into the on-wire FCS value.
  function automatic logic [31:0] crc_reverse_invert(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  function automatic logic [31:0] crc32_update_byte(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {crc_reverse_byte(data), 24'h0};
    for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/fcs_delay_line.sv
// 4-byte delay line for the FCS checker. It holds back the newest bytes so
// that the trailing FCS never enters the CRC.
//  clk, rst_n   clock / async active-low reset
//  shift        valid byte to push (ignored while restart is high)
//  restart      drop contents and load data_in as the only byte
//  data_in      byte to push
//  head         three newest held bytes {taps[2],taps[1],taps[0]}; taps[0] is the newest
//  evict_byte   oldest byte, which leaves the line on a shift when the line is full
//  evict_valid  evict_byte is consumed this cycle
module fcs_delay_line (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift,
  input  logic        restart,
  input  logic [7:0]  data_in,
  output logic [23:0] head,
  output logic [7:0]  evict_byte,
  output logic        evict_valid
);
  logic [3:0][7:0] taps;
  logic [2:0]      fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
      fill <= '0;
    end else if (restart) begin
      taps <= {24'h0, data_in};
      fill <= 3'd1;
    end else if (shift) begin
      taps <= {taps[2:0], data_in};
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  assign head        = taps[2:0];
  assign evict_byte  = taps[3];
  assign evict_valid = shift && !restart && (fill == 3'd4);
endmodule

// File: rtl/eth_fcs_checker.sv
// Receive-side Ethernet FCS checker. It computes CRC-32 over every frame byte
// except the trailing four and compares the result with the received FCS.
//  clk, rst_n    clock / async active-low reset
//  data_in       received byte, in first-on-wire order; data_valid qualifies it
//  sof / eof     first / last (FCS byte 3) byte markers, qualified by data_valid
//  frame_done    1-cycle pulse, high on the cycle after the eof beat
//  fcs_ok/err    FCS match / mismatch (a frame shorter than 5 bytes is an error)
//  runt          frame shorter than MIN_FRAME_BYTES
//  rx_fcs        received FCS, packed {b3,b2,b1,b0}
//  calc_fcs      computed FCS, same packing as rx_fcs
//  frame_len     frame length including FCS; saturates at the counter maximum
module eth_fcs_checker
  import crc_32_byte_package::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             sof,
  input  logic             eof,
  output logic             frame_done,
  output logic             fcs_ok,
  output logic             fcs_err,
  output logic             runt,
  output logic [31:0]      rx_fcs,
  output logic [31:0]      calc_fcs,
  output logic [CNT_W-1:0] frame_len
);
  fcs_chk_state_t   state_q, state_d;
  logic             restart, shift, finish;
  logic [CNT_W-1:0] cnt_q, len_d;
  logic [31:0]      crc_q, crc_d, calc_now, rx_now;
  logic [23:0]      head;
  logic [7:0]       evict_byte;
  logic             evict_valid, short_frame, match;

  // sof always wins, so a sof in RX aborts the frame and starts again.
  // sof and eof on the same beat form a complete 1-byte frame.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    if (data_valid) begin
      if (sof) begin
        restart = 1'b1;
        finish  = eof;
        state_d = eof ? IDLE : RX;
      end else if (state_q == RX) begin
        shift = 1'b1;
        if (eof) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  fcs_delay_line u_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift      (shift),
    .restart    (restart),
    .data_in    (data_in),
    .head       (head),
    .evict_byte (evict_byte),
    .evict_valid(evict_valid)
  );

  // The byte evicted on the eof beat is the last payload byte. It is folded
  // in here so that the result can be latched on the same edge.
  assign crc_d    = evict_valid ? crc32_update_byte(crc_q, evict_byte) : crc_q;
  assign calc_now = crc_reverse_invert(crc_d);
  assign rx_now   = {data_in, head[7:0], head[15:8], head[23:16]};
  assign len_d    = restart ? CNT_W'(1)
                  : (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign short_frame = len_d < CNT_W'(5);
  assign match       = (rx_now == calc_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      crc_q      <= CRC_INITIAL_VALUE;
      frame_done <= 1'b0;
      fcs_ok     <= 1'b0;
      fcs_err    <= 1'b0;
      runt       <= 1'b0;
      rx_fcs     <= '0;
      calc_fcs   <= '0;
      frame_len  <= '0;
    end else begin
      if (restart) begin
        cnt_q <= len_d;
        crc_q <= CRC_INITIAL_VALUE;
      end else if (shift) begin
        cnt_q <= len_d;
        crc_q <= crc_d;
      end
      frame_done <= finish;
      if (finish) begin
        rx_fcs    <= rx_now;
        calc_fcs  <= calc_now;
        fcs_ok    <= !short_frame && match;
        fcs_err   <= short_frame || !match;
        runt      <= len_d < CNT_W'(MIN_FRAME_BYTES);
        frame_len <= len_d;
      end
    end
  end
endmodule
